alu_nbit_seq: RTL

ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_shift_add_mul.sv | 64 ++++++
 rtl/alu_nbit_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings,
// the flag bundle, and small helpers for overflow and carry ownership.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_SAR = 4'b1000,
    OP_ADC = 4'b1001,
    OP_SBB = 4'b1010,
    OP_MUL = 4'b1011
  } op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic negative;
  } flags_t;

  // Signed overflow of a + b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic y_msb);
    return (a_msb == b_msb) && (y_msb != a_msb);
  endfunction

  // Signed overflow of a - b: operands differ in sign, result differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic y_msb);
    return (a_msb != b_msb) && (y_msb != a_msb);
  endfunction

  // Only arithmetic and shift results feed the internal carry used by ADC/SBB.
  function automatic logic writes_carry(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_SHL, OP_SHR, OP_SAR: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Unsigned shift-add multiplier. A start pulse loads the operands; exactly
// WIDTH iterations later done pulses for one cycle with the 2*WIDTH product.
module alu_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);

  // Upper half accumulates partial sums, lower half holds the remaining
  // multiplier bits; each step shifts the whole register right by one.
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH:0]     partial;

  // Add the multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
  end

  // Iteration register: load on start, one shift-add step per cycle while busy.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would chain updates within one edge.
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        prod_q  <= {{WIDTH{1'b0}}, b};
        mcand_q <= a;
        cnt_q   <= CW'(WIDTH);
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        prod_q <= {partial, prod_q[WIDTH-1:1]};
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign lo   = prod_q[WIDTH-1:0];
  assign hi   = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_nbit_seq.sv
// Sequential N-bit ALU with valid/ready handshakes on both sides. Single-cycle
// ops register their result on the accept edge; MUL runs on the shift-add
// sub-module and returns WIDTH+1 cycles after accept. The output register
// holds its result until the consumer takes it.
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  localparam int               MSB       = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

  state_e state_q, state_d;
  op_e    op_dec;
  logic   accept;
  logic   load_alu;
  logic   load_mul;
  logic   mul_start;
  logic   mul_done;
  logic [WIDTH-1:0] mul_lo, mul_hi;

  logic   c_q;
  flags_t flags_q;

  logic [WIDTH-1:0] alu_y;
  flags_t           alu_flags;
  logic             alu_c_wr;
  logic             c_in;
  logic             shamt_over;
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext, sar_ext;

  assign op_dec = op_e'(op);

  // Control: handshake, FSM next state and load strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = !rst && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        if (accept) begin
          if (op_dec == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL_BUSY;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          load_mul = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single-cycle datapath for everything except MUL.
  always_comb begin
    alu_y      = '0;
    alu_flags  = '0;
    alu_c_wr   = writes_carry(op_dec);
    c_in       = (op_dec == OP_ADC || op_dec == OP_SBB) ? c_q : 1'b0;
    add_ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    sub_ext    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
    // Extended shifts keep the last bit shifted out in the extra position.
    shl_ext    = {1'b0, a} << b;
    shr_ext    = {a, 1'b0} >> b;
    sar_ext    = $signed({a, 1'b0}) >>> b;
    shamt_over = (b > WIDTH_VAL);
    unique case (op_dec)
      OP_ADD, OP_ADC: begin
        alu_y              = add_ext[WIDTH-1:0];
        alu_flags.carry    = add_ext[WIDTH];
        alu_flags.overflow = add_ovf(a[MSB], b[MSB], add_ext[MSB]);
      end
      OP_SUB, OP_SBB: begin
        // The sign bit of the extended difference is the borrow.
        alu_y              = sub_ext[WIDTH-1:0];
        alu_flags.carry    = sub_ext[WIDTH];
        alu_flags.overflow = sub_ovf(a[MSB], b[MSB], sub_ext[MSB]);
      end
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_XOR: alu_y = a ^ b;
      OP_NOT: alu_y = ~a;
      OP_SHL: begin
        alu_y           = shl_ext[WIDTH-1:0];
        alu_flags.carry = shamt_over ? 1'b0 : shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_y           = shr_ext[WIDTH:1];
        alu_flags.carry = shamt_over ? 1'b0 : shr_ext[0];
      end
      OP_SAR: begin
        // Beyond WIDTH the result is all sign bits but no real bit left last.
        alu_y           = sar_ext[WIDTH:1];
        alu_flags.carry = shamt_over ? 1'b0 : sar_ext[0];
      end
      default: alu_y = '0;
    endcase
    alu_flags.zero     = (alu_y == '0);
    alu_flags.negative = alu_y[MSB];
  end

  alu_shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .a    (a),
    .b    (b),
    .done (mul_done),
    .lo   (mul_lo),
    .hi   (mul_hi)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Output register and internal carry: load a new result, else release on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_hi      <= '0;
      flags_q   <= '0;
      c_q       <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      y         <= alu_y;
      y_hi      <= '0;
      flags_q   <= alu_flags;
      if (alu_c_wr) c_q <= alu_flags.carry;
    end else if (load_mul) begin
      out_valid        <= 1'b1;
      y                <= mul_lo;
      y_hi             <= mul_hi;
      flags_q.carry    <= 1'b0;
      flags_q.zero     <= (mul_lo == '0);
      flags_q.overflow <= (mul_hi != '0);
      flags_q.negative <= mul_lo[MSB];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign carry    = flags_q.carry;
  assign zero     = flags_q.zero;
  assign overflow = flags_q.overflow;
  assign negative = flags_q.negative;

endmodule
